cache_tag_lookup: RTL and testbench

Tag-store and hit-detection stage of the 4-way set-associative cache, directly downstream of the address decoder. Accepts the decoded 26-bit tag and 4-bit set index, compares against four ways of stored tags, and returns hit/way or a replacement victim one cycle later. Holds valid, dirty and tree pseudo-LRU state per set, and supports line fills plus a sequenced whole-cache flush for the cache controller.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_tag_lookup_if.sv | 46 ++++
 rtl/plru_tree4.sv | 26 ++
 rtl/cache_tag_lookup.sv | 161 ++++++++++++++++
 tb/tb_cache_tag_lookup.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-way set-associative cache tag stage.
package cache_pkg;

  localparam int TAG_W    = 26;
  localparam int INDEX_W  = 4;
  localparam int NUM_SETS = 1 << INDEX_W;
  localparam int NUM_WAYS = 4;

  typedef logic [1:0]         way_t;
  typedef logic [2:0]         plru_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [TAG_W-1:0]   tag_t;

  typedef enum logic {
    READY = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cache_tag_lookup_if.sv
// Lookup, response, fill and flush signals between the cache controller
// and the tag stage. The controller side is master, the tag stage is slave.
interface cache_tag_lookup_if
  import cache_pkg::*;
  ();

  logic   req_valid;
  logic   req_ready;
  tag_t   req_tag;
  index_t req_index;
  logic   req_write;

  logic   rsp_valid;
  logic   rsp_hit;
  way_t   rsp_way;
  tag_t   rsp_victim_tag;
  logic   rsp_victim_dirty;

  logic   fill_valid;
  index_t fill_index;
  way_t   fill_way;
  tag_t   fill_tag;
  logic   fill_dirty;

  logic   flush_req;
  logic   flush_done;

  modport master (
    output req_valid, req_tag, req_index, req_write,
    output fill_valid, fill_index, fill_way, fill_tag, fill_dirty,
    output flush_req,
    input  req_ready,
    input  rsp_valid, rsp_hit, rsp_way, rsp_victim_tag, rsp_victim_dirty,
    input  flush_done
  );

  modport slave (
    input  req_valid, req_tag, req_index, req_write,
    input  fill_valid, fill_index, fill_way, fill_tag, fill_dirty,
    input  flush_req,
    output req_ready,
    output rsp_valid, rsp_hit, rsp_way, rsp_victim_tag, rsp_victim_dirty,
    output flush_done
  );

endinterface

// File: rtl/plru_tree4.sv
// Tree pseudo-LRU for one 4-way set: victim select and post-access update.
// Bit 0 picks the half to evict from; bits 1 and 2 pick within the lower
// and upper half respectively.
module plru_tree4
  import cache_pkg::*;
(
  input  plru_t bits,
  input  way_t  access_way,
  output way_t  victim,
  output plru_t bits_nxt
);

  // Victim from current bits; next bits point away from the accessed way.
  always_comb begin
    victim   = bits[0] ? (bits[2] ? way_t'(2'd3) : way_t'(2'd2))
                       : (bits[1] ? way_t'(2'd1) : way_t'(2'd0));
    bits_nxt = bits;
    bits_nxt[0] = ~access_way[1];
    if (!access_way[1]) begin
      bits_nxt[1] = ~access_way[0];
    end else begin
      bits_nxt[2] = ~access_way[0];
    end
  end

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag store and hit detection for the 4-way cache. Lookups resolve in the
// accept cycle and are reported one cycle later; fills and whole-cache
// flushes come from the cache controller.
//
// state | meaning
// READY | accepting fills and lookups
// FLUSH | clearing one set per cycle, sets 0..15
module cache_tag_lookup
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  cache_tag_lookup_if.slave bus
);

  state_t state, state_nxt;
  index_t flush_cnt;
  logic   flush_last;
  logic   flush_done_q;

  tag_t                tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  plru_t               plru_q  [NUM_SETS];

  logic                fill_en;
  logic                accept;
  logic                hit;
  logic [NUM_WAYS-1:0] match;
  logic [NUM_WAYS-1:0] set_valid;
  logic [NUM_WAYS-1:0] set_dirty;
  way_t                hit_way;
  way_t                victim_way;
  way_t                plru_victim;
  way_t                acc_way;
  index_t              plru_idx;
  plru_t               plru_cur;
  plru_t               plru_nxt;

  logic rsp_valid_q;
  logic rsp_hit_q;
  way_t rsp_way_q;
  tag_t rsp_victim_tag_q;
  logic rsp_victim_dirty_q;

  assign flush_last    = (state == FLUSH) && (flush_cnt == index_t'(NUM_SETS - 1));
  assign bus.req_ready = (state == READY) & ~bus.fill_valid & ~bus.flush_req;
  assign accept        = bus.req_valid & bus.req_ready;
  // A flush request in the same cycle wins over a fill.
  assign fill_en       = bus.fill_valid & (state == READY) & ~bus.flush_req;

  // Next-state logic for the ready/flush sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (bus.flush_req) state_nxt = FLUSH;
      FLUSH:   if (flush_last)    state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // State register, flush set counter and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= READY;
      flush_cnt    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_done_q <= flush_last;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + index_t'(1);
      end
    end
  end

  // Tag compare against the addressed set; lowest matching / invalid way wins.
  always_comb begin
    set_valid  = valid_q[bus.req_index];
    set_dirty  = dirty_q[bus.req_index];
    match      = '0;
    hit_way    = '0;
    victim_way = plru_victim;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = set_valid[w] && (tag_q[bus.req_index][w] == bus.req_tag);
    end
    hit = |match;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w])      hit_way    = way_t'(w);
      if (!set_valid[w]) victim_way = way_t'(w);
    end
  end

  // Fill and lookup never update PLRU in the same cycle, so one tree serves both.
  assign plru_idx = fill_en ? bus.fill_index : bus.req_index;
  assign acc_way  = fill_en ? bus.fill_way   : hit_way;
  assign plru_cur = plru_q[plru_idx];

  plru_tree4 u_plru (
    .bits       (plru_cur),
    .access_way (acc_way),
    .victim     (plru_victim),
    .bits_nxt   (plru_nxt)
  );

  // Tag/valid/dirty/PLRU storage: fills, hit updates and flush clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      if (fill_en) begin
        tag_q[bus.fill_index][bus.fill_way]   <= bus.fill_tag;
        valid_q[bus.fill_index][bus.fill_way] <= 1'b1;
        dirty_q[bus.fill_index][bus.fill_way] <= bus.fill_dirty;
        plru_q[bus.fill_index]                <= plru_nxt;
      end else if (accept && hit) begin
        plru_q[bus.req_index] <= plru_nxt;
        if (bus.req_write) begin
          dirty_q[bus.req_index][hit_way] <= 1'b1;
        end
      end
      if (state == FLUSH) begin
        valid_q[flush_cnt] <= '0;
        dirty_q[flush_cnt] <= '0;
        plru_q[flush_cnt]  <= '0;
      end
    end
  end

  // Registered lookup result; victim fields stay zero on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q        <= 1'b0;
      rsp_hit_q          <= 1'b0;
      rsp_way_q          <= '0;
      rsp_victim_tag_q   <= '0;
      rsp_victim_dirty_q <= 1'b0;
    end else begin
      rsp_valid_q        <= accept;
      rsp_hit_q          <= accept & hit;
      rsp_way_q          <= accept ? (hit ? hit_way : victim_way) : way_t'(2'd0);
      rsp_victim_tag_q   <= (accept && !hit) ? tag_q[bus.req_index][victim_way] : '0;
      rsp_victim_dirty_q <= accept & ~hit & set_valid[victim_way] & set_dirty[victim_way];
    end
  end

  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_hit          = rsp_hit_q;
  assign bus.rsp_way          = rsp_way_q;
  assign bus.rsp_victim_tag   = rsp_victim_tag_q;
  assign bus.rsp_victim_dirty = rsp_victim_dirty_q;
  assign bus.flush_done       = flush_done_q;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: lookups, fills, PLRU victim choice,
// flush sequencing and asynchronous reset.
module tb_cache_tag_lookup;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_tag_lookup_if bus ();

  cache_tag_lookup dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one lookup and check the response; e_vtag < 0 skips the victim tag.
  task automatic look(input string nm, input logic [25:0] tag, input logic [3:0] idx,
                      input logic wr, input int e_hit, input int e_way,
                      input int e_vtag, input int e_vdirty);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    bus.req_index = idx;
    bus.req_write = wr;
    #1;
    check({nm, ".ready"}, 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    check({nm, ".valid"}, 32'(bus.rsp_valid), 1);
    check({nm, ".hit"}, 32'(bus.rsp_hit), 32'(e_hit));
    check({nm, ".way"}, 32'(bus.rsp_way), 32'(e_way));
    if (e_vtag >= 0) check({nm, ".vtag"}, 32'(bus.rsp_victim_tag), 32'(e_vtag));
    check({nm, ".vdirty"}, 32'(bus.rsp_victim_dirty), 32'(e_vdirty));
  endtask

  task automatic fill(input logic [3:0] idx, input logic [1:0] way,
                      input logic [25:0] tag, input logic dirty);
    bus.fill_valid = 1'b1;
    bus.fill_index = idx;
    bus.fill_way   = way;
    bus.fill_tag   = tag;
    bus.fill_dirty = dirty;
    @(posedge clk);
    #1;
    bus.fill_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_cnt;
    int done_cnt;
    int done_at;

    bus.req_valid  = 1'b0;
    bus.req_tag    = '0;
    bus.req_index  = '0;
    bus.req_write  = 1'b0;
    bus.fill_valid = 1'b0;
    bus.fill_index = '0;
    bus.fill_way   = '0;
    bus.fill_tag   = '0;
    bus.fill_dirty = 1'b0;
    bus.flush_req  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst.flush_done", 32'(bus.flush_done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready", 32'(bus.req_ready), 1);

    look("cold_miss", 26'hABC, 4'd3, 1'b0, 0, 0, 0, 0);

    // Set 5 filled in way order leaves PLRU bits at 000.
    for (int w = 0; w < 4; w++) fill(4'd5, 2'(w), 26'(32'h10 + w), 1'b0);
    look("wr_hit2", 26'h12, 4'd5, 1'b1, 1, 2, 0, 0);
    look("rehit2",  26'h12, 4'd5, 1'b0, 1, 2, 0, 0);
    look("miss_v0", 26'h99, 4'd5, 1'b0, 0, 0, 26'h10, 0);
    look("wr_hit0", 26'h10, 4'd5, 1'b1, 1, 0, 0, 0);
    look("miss_v3", 26'h99, 4'd5, 1'b0, 0, 3, 26'h13, 0);
    look("hit3",    26'h13, 4'd5, 1'b0, 1, 3, 0, 0);
    look("hit1",    26'h11, 4'd5, 1'b0, 1, 1, 0, 0);
    look("miss_v2", 26'h99, 4'd5, 1'b0, 0, 2, 26'h12, 1);

    // Fill and lookup together: fill wins, no response.
    bus.req_valid = 1'b1;
    bus.req_tag   = 26'h70;
    bus.req_index = 4'd7;
    for (int i = 0; i < 3; i++) begin
      bus.fill_valid = 1'b1;
      bus.fill_index = 4'd7;
      bus.fill_way   = 2'(i);
      bus.fill_tag   = 26'(32'h70 + i);
      bus.fill_dirty = 1'b0;
      #1;
      check("fill_prio.ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
      check("fill_prio.rsp_valid", 32'(bus.rsp_valid), 0);
    end
    bus.fill_valid = 1'b0;
    bus.req_valid  = 1'b0;
    look("fill_hit1", 26'h71, 4'd7, 1'b0, 1, 1, 0, 0);
    look("fill_hit2", 26'h72, 4'd7, 1'b0, 1, 2, 0, 0);

    // Async reset kills a pending response.
    bus.req_valid = 1'b1;
    bus.req_tag   = 26'h12;
    bus.req_index = 4'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("pend.rsp_valid", 32'(bus.rsp_valid), 1);
    check("pend.rsp_hit", 32'(bus.rsp_hit), 1);
    rst_n = 1'b0;
    #1;
    check("arst.rsp_valid", 32'(bus.rsp_valid), 0);
    check("arst.rsp_hit", 32'(bus.rsp_hit), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("arst_miss", 26'h12, 4'd5, 1'b0, 0, 0, -1, 0);

    // Whole-cache flush.
    fill(4'd0, 2'd0, 26'hA0, 1'b1);
    fill(4'd15, 2'd3, 26'hF3, 1'b1);
    look("pre_hit0",  26'hA0, 4'd0,  1'b0, 1, 0, 0, 0);
    look("pre_hit15", 26'hF3, 4'd15, 1'b0, 1, 3, 0, 0);
    bus.flush_req = 1'b1;
    #1;
    lo_cnt   = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.req_ready) lo_cnt++;
      if (bus.flush_done) begin
        done_cnt++;
        done_at = i;
      end
      @(posedge clk);
      #1;
      bus.flush_req = 1'b0;
    end
    check("flush.ready_low", 32'(lo_cnt), 17);
    check("flush.done_pulses", 32'(done_cnt), 1);
    check("flush.done_at", 32'(done_at), 17);
    look("post_flush0",  26'hA0, 4'd0,  1'b0, 0, 0, -1, 0);
    look("post_flush15", 26'hF3, 4'd15, 1'b0, 0, 0, -1, 0);

    // Reset in FLUSH cycle 7.
    fill(4'd2, 2'd1, 26'h21, 1'b0);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midflush.ready", 32'(bus.req_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midflush_rst.rsp_valid", 32'(bus.rsp_valid), 0);
    check("midflush_rst.flush_done", 32'(bus.flush_done), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midflush_rel.ready", 32'(bus.req_ready), 1);
    lo_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.req_ready) lo_cnt++;
      if (bus.flush_done) done_cnt++;
      @(posedge clk);
      #1;
    end
    check("midflush_rel.ready_low", 32'(lo_cnt), 0);
    check("midflush_rel.done", 32'(done_cnt), 0);
    for (int s = 0; s < 16; s++) begin
      look($sformatf("rst_set%0d", s), 26'h21, 4'(s), 1'b0, 0, 0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
